fir_tap_sequencer: RTL and testbench
====================================

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 Parameter TAPS, default 8, number of filter taps (legal 2..64).
REQ-002 Parameter SHIFT, default 15, right-shift applied to accumulator on output (legal 1..23).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 R  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 in_valid  input  1  new input sample offered.
REQ-006 in_ready  output  1  sequencer can accept a sample.
REQ-007 in_data  input  16  signed input sample.
REQ-008 coef_we  input  1  coefficient write strobe.
REQ-009 coef_addr  input  6  coefficient index.
REQ-010 coef_data  input  16  signed coefficient (Q1.15 when SHIFT=15).
REQ-011 alu_x  output  16  signed sample operand to the MAC ALU X port.
REQ-012 alu_b  output  16  signed coefficient operand to the MAC ALU B port.
REQ-013 alu_r  output  1  accumulator clear to the MAC ALU R port.
REQ-014 alu_y  input  39  signed accumulator value from the MAC ALU y port.
REQ-015 out_valid  output  1  filtered sample available.
REQ-016 out_ready  input  1  consumer accepts out_data.
REQ-017 out_data  output  16  signed filtered sample.

Function
REQ-018 FSM states IDLE, CLR, MAC, CAP; IDLE->CLR on in_valid&in_ready; CLR->MAC after one cycle; MAC->CAP after TAPS cycles; CAP->IDLE on the edge the result is captured.
REQ-019 in_ready SHALL be 1 only in IDLE; handshake completes on an edge with in_valid&in_ready.
REQ-020 Accepted sample SHALL be written to a TAPS-entry circular delay line at wptr; wptr increments mod TAPS (TAPS-1 wraps to 0).
REQ-021 alu_r SHALL be 1 in CLR and while R is high, else 0.
REQ-022 In MAC cycle k (k=0..TAPS-1): alu_x = delay[(wptr_written - k) mod TAPS], alu_b = coef[k]; k=0 is the newest sample.
REQ-023 In IDLE, CLR and CAP, alu_x and alu_b SHALL be 0 so the ALU accumulator holds its value.
REQ-024 CAP: when out_valid=0 or out_ready=1, register out_data = sat16((alu_y + 2^(SHIFT-1)) >>> SHIFT), set out_valid=1, go IDLE; otherwise stay in CAP (stall, accumulator held by REQ-023).
REQ-025 Rounding SHALL be round-half-up on the 39-bit signed value; saturation clamps to [-32768, 32767].
REQ-026 Latency: sample accepted on edge E SHALL produce out_valid=1 after edge E+TAPS+2 when the output is free.
REQ-027 out_valid SHALL clear on an edge with out_ready=1 and no simultaneous capture; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Simultaneous capture and consumption: out_valid stays 1, out_data takes the new value.
REQ-029 coef_we SHALL write coef[coef_addr] only in IDLE with coef_addr < TAPS; otherwise ignored.
REQ-030 in_valid outside IDLE SHALL be ignored (no delay-line write, no wptr change).

Reset
REQ-031 While R is high: state=IDLE, wptr=0, all delay entries=0, all coefs=0, out_valid=0, out_data=0, alu_x=0, alu_b=0, alu_r=1.
REQ-032 R asserted mid-CLR/MAC/CAP SHALL abort the computation; no out_valid for the aborted sample; in_ready=1 on the first cycle after release.

Verification
REQ-033 TAPS=4, SHIFT=15, coefs all 0x4000, impulse 0x7FFF then zeros -> out_data 0x4000 for 4 outputs, then 0x0000.
REQ-034 Coefs all 0x7FFF, four inputs 0x7FFF -> 4th output 0x7FFF (saturated); four inputs 0x8000 -> 0x8000.
REQ-035 Single accepted sample, out_ready=1 -> alu_r high exactly 1 cycle, out_valid rises after edge E+TAPS+2, in_ready returns 1 with out_valid.
REQ-036 out_ready=0 for 20 cycles with two samples sent -> first out_data stable, second held in CAP, in_ready=0; raise out_ready -> both outputs delivered in order with correct values.
REQ-037 R pulsed during MAC k=2 -> out_valid stays 0, next impulse 0x7FFF with coefs 0x4000 yields 0x4000 with no residue from pre-reset samples.
REQ-038 coef_we during MAC and coef_we with coef_addr=TAPS in IDLE -> coefficient set unchanged, outputs unchanged.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
// Time-multiplexed FIR control for an external MAC ALU. For each accepted
// input sample it clears the ALU accumulator for one cycle and then feeds it
// TAPS sample/coefficient pairs, newest sample first. It then rounds,
// shifts and saturates the accumulator into a 16-bit output register.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid
// and ready are both 1. in_ready depends only on state. out_valid/out_data
// hold steady until out_ready is seen.
//
// Ports:
//   clk        sole clock
//   R          asynchronous active-high reset
//   in_valid   / in_ready / in_data      input sample stream (signed 16)
//   coef_we    / coef_addr / coef_data   coefficient writes, IDLE only
//   alu_x, alu_b                         MAC operands (0 outside MAC)
//   alu_r                                accumulator clear
//   alu_y                                39-bit signed accumulator
//   out_valid  / out_ready / out_data    filtered sample stream
//   dbg_state                            current FSM state
module fir_tap_sequencer #(
  parameter int TAPS  = 8,
  parameter int SHIFT = 15
) (
  input  logic               clk,
  input  logic               R,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  input  logic               coef_we,
  input  logic        [5:0]  coef_addr,
  input  logic signed [15:0] coef_data,
  output logic signed [15:0] alu_x,
  output logic signed [15:0] alu_b,
  output logic               alu_r,
  input  logic signed [38:0] alu_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic        [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    MAC  = 2'd2,
    CAP  = 2'd3
  } state_t;

  localparam int PW = $clog2(TAPS);
  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic signed [39:0] HALF = 40'sd1 <<< (SHIFT - 1);

  state_t state_q, state_d;

  logic [PW-1:0]      wptr;    // next delay-line slot to write
  logic [PW-1:0]      rptr;    // delay-line slot read in the current MAC cycle
  logic [PW-1:0]      kcnt;    // tap index k in MAC
  logic signed [15:0] delay [TAPS];
  logic signed [15:0] coef  [TAPS];

  logic               accept;
  logic               cap_fire;
  logic               coef_ok;
  logic signed [39:0] rnd_sum;
  logic signed [39:0] rnd_shift;
  logic signed [15:0] sat_val;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  // Capture only when the output register is empty or being drained now.
  assign cap_fire  = (state_q == CAP) && (!out_valid || out_ready);
  assign coef_ok   = ({1'b0, coef_addr} < 7'(TAPS));
  assign dbg_state = state_q;

  // Operands are forced to zero outside MAC so the accumulator holds.
  assign alu_x = (state_q == MAC) ? delay[rptr] : 16'sd0;
  assign alu_b = (state_q == MAC) ? coef[kcnt]  : 16'sd0;
  assign alu_r = R || (state_q == CLR);

  // Round half up on the full accumulator, then clamp to 16 bits.
  assign rnd_sum   = {alu_y[38], alu_y} + HALF;
  assign rnd_shift = rnd_sum >>> SHIFT;

  always_comb begin
    sat_val = rnd_shift[15:0];
    if (rnd_shift > 40'sd32767) begin
      sat_val = 16'sh7FFF;
    end else if (rnd_shift < -40'sd32768) begin
      sat_val = 16'sh8000;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CLR;
      CLR:  state_d = MAC;
      MAC:  if (kcnt == LAST) state_d = CAP;
      CAP:  if (cap_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      wptr <= '0;
      rptr <= '0;
      kcnt <= '0;
      for (int i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      if (accept) begin
        delay[wptr] <= in_data;
        // MAC walks backwards from the slot just written (newest sample).
        rptr <= wptr;
        wptr <= (wptr == LAST) ? '0 : wptr + ONE;
      end
      if (state_q == CLR) begin
        kcnt <= '0;
      end
      if (state_q == MAC) begin
        kcnt <= kcnt + ONE;
        rptr <= (rptr == '0) ? LAST : rptr - ONE;
      end
      if (coef_we && (state_q == IDLE) && coef_ok) begin
        coef[coef_addr[PW-1:0]] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cap_fire) begin
      out_valid <= 1'b1;
      out_data  <= sat_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer
// Bench for fir_tap_sequencer with TAPS=4, SHIFT=15. It contains a
// registered MAC ALU model that closes the loop on alu_x/alu_b/alu_r/alu_y.
// Expected outputs come from an arithmetic FIR model: newest-first sample
// history times coefficient table, then round, shift and saturate. Directed
// tests compare collected outputs against hand-computed literals.
module tb_fir_tap_sequencer;

  localparam int TAPS  = 4;
  localparam int SHIFT = 15;

  logic               clk;
  logic               R;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               coef_we;
  logic        [5:0]  coef_addr;
  logic signed [15:0] coef_data;
  logic signed [15:0] alu_x;
  logic signed [15:0] alu_b;
  logic               alu_r;
  logic signed [38:0] alu_y;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic        [1:0]  dbg_state;

  fir_tap_sequencer #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk(clk), .R(R),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .alu_x(alu_x), .alu_b(alu_b), .alu_r(alu_r), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered MAC ALU
  logic signed [38:0] acc;
  always_ff @(posedge clk) begin
    if (alu_r) acc <= '0;
    else       acc <= acc + 39'(alu_x) * 39'(alu_b);
  end
  assign alu_y = acc;

  // scoreboard and model state
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int hist[$];            // accepted samples, newest first
  int coef_m[TAPS];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out();
    longint s = 0;
    for (int k = 0; k < hist.size(); k++) s += longint'(coef_m[k]) * longint'(hist[k]);
    s = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic model_accept(input logic [15:0] d);
    hist.push_front(int'($signed(d)));
    if (hist.size() > TAPS) void'(hist.pop_back());
    exp_q.push_back(model_out());
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
  endtask

  // compare process: every delivered output is checked against the model,
  // and a held output must not change while the consumer stalls
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = '0;
  always @(negedge clk) begin
    if (R) begin
      hold_v = 1'b0;
    end else begin
      if (out_valid && hold_v) check("out_stable", out_data, hold_d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        got_q.push_back(out_data);
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_d = out_data;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // driver tasks (all start just after a rising edge)
  task automatic send(input logic [15:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 at %0t", $time);
      @(posedge clk);
    end else begin
      @(posedge clk);
      model_accept(d);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wr_coef(input logic [5:0] a, input logic [15:0] d);
    int g = 0;
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    if (in_ready && int'(a) < TAPS) coef_m[a] = int'($signed(d));
    #1 coef_we = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < TAPS; i++) send(16'h0000);
    drain();
  endtask

  // watchdog
  initial begin
    #300000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // main sequence
  initial begin
    int r_cnt;
    R = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_r", 16'(alu_r), 16'h1);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_alu_x", alu_x, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    @(posedge clk);
    #1 R = 1'b0;

    // impulse response with half-scale coefficients
    for (int i = 0; i < TAPS; i++) wr_coef(6'(i), 16'h4000);
    got_q.delete();
    send(16'h7FFF);
    for (int i = 0; i < TAPS; i++) send(16'h0000);
    drain();
    check("imp_count", 16'(got_q.size()), 16'd5);
    check("imp_0", got_q[0], 16'h4000);
    check("imp_1", got_q[1], 16'h4000);
    check("imp_2", got_q[2], 16'h4000);
    check("imp_3", got_q[3], 16'h4000);
    check("imp_4", got_q[4], 16'h0000);

    // latency, single clear pulse, in_ready returning with out_valid
    got_q.delete();
    in_valid = 1'b1;
    in_data  = 16'h1000;
    @(negedge clk);
    check("lat_in_ready", 16'(in_ready), 16'h1);
    @(posedge clk);
    model_accept(16'h1000);
    #1 in_valid = 1'b0;
    r_cnt = 0;
    for (int n = 1; n <= TAPS + 3; n++) begin
      @(negedge clk);
      if (alu_r) r_cnt++;
      check("lat_out_valid", 16'(out_valid), 16'(n == TAPS + 3));
      check("lat_in_ready", 16'(in_ready), 16'(n == TAPS + 3));
    end
    check("lat_alu_r_pulses", 16'(r_cnt), 16'd1);
    drain();
    check("lat_value", got_q[0], 16'h0800);

    // saturation both ways
    for (int i = 0; i < TAPS; i++) wr_coef(6'(i), 16'h7FFF);
    got_q.delete();
    for (int i = 0; i < 4; i++) send(16'h7FFF);
    for (int i = 0; i < 4; i++) send(16'h8000);
    drain();
    check("sat_pos", got_q[3], 16'h7FFF);
    check("sat_neg", got_q[7], 16'h8000);

    // output back-pressure with two samples in flight
    flush();
    got_q.delete();
    out_ready = 1'b0;
    send(16'h0100);
    send(16'h0200);
    repeat (20) @(negedge clk);
    check("bp_in_ready", 16'(in_ready), 16'h0);
    check("bp_out_valid", 16'(out_valid), 16'h1);
    check("bp_out_data", out_data, 16'h0100);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("bp_count", 16'(got_q.size()), 16'd2);
    check("bp_first", got_q[0], 16'h0100);
    check("bp_second", got_q[1], 16'h0300);

    // coefficient writes that must be ignored
    flush();
    got_q.delete();
    send(16'h2000);
    coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'h1111;
    repeat (TAPS + 1) @(posedge clk);
    #1 coef_we = 1'b0;
    drain();
    wr_coef(6'(TAPS), 16'h5555);
    send(16'h2000);
    drain();
    check("cw_first", got_q[0], 16'h2000);
    check("cw_second", got_q[1], 16'h4000);

    // reset in the middle of MAC (k=2)
    send(16'h7FFF);
    send(16'h7FFF);
    drain();
    got_q.delete();
    send(16'h7FFF);
    repeat (3) @(posedge clk);
    #2 R = 1'b1;
    model_reset();
    @(negedge clk);
    check("abort_alu_r", 16'(alu_r), 16'h1);
    check("abort_out_valid", 16'(out_valid), 16'h0);
    check("abort_alu_x", alu_x, 16'h0000);
    @(posedge clk);
    #1 R = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 16'(in_ready), 16'h1);
    for (int n = 0; n < TAPS + 4; n++) begin
      @(negedge clk);
      check("abort_no_valid", 16'(out_valid), 16'h0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < TAPS; i++) wr_coef(6'(i), 16'h4000);
    send(16'h7FFF);
    send(16'h0000);
    drain();
    check("post_rst_count", 16'(got_q.size()), 16'd2);
    check("post_rst_0", got_q[0], 16'h4000);
    check("post_rst_1", got_q[1], 16'h4000);

    check("final_pending", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
